// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the data-memory/MMIO port between the CPU
// load/store path and a debug/loader requester that issues word bursts.
// The CPU owns the port except during BURST beats, when cpu_stall tells
// the CPU to hold its instruction.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to force a CPU slot
// after STARVE_LIMIT consecutive stalled beats inside a burst. That
// parameter only exists when the macro is defined.
module mem_port_arbiter #(
  parameter int MAX_LEN = 16
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STARVE_LIMIT = 8
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_load,
  input  logic        cpu_store,
  input  logic [2:0]  cpu_access,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [7:0]  dbg_len,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic        dbg_valid,
  output logic [31:0] dbg_rdata,
  output logic        dbg_done,
  output logic        mem_load,
  output logic        mem_store,
  output logic [2:0]  mem_access,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_LEN_C = 8'(MAX_LEN);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        done_q, done_d;

  logic [7:0]  eff_len_s;
  logic        cpu_req_s;
  logic        slot_s;
  logic        own_dbg_s;

  assign cpu_req_s = cpu_load | cpu_store;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam logic [7:0] STARVE_C = 8'(STARVE_LIMIT);

  logic [7:0] starve_q, starve_d;

  // A burst cycle becomes a CPU slot once enough stalled beats have piled up.
  assign slot_s = (state_q == S_BURST) && (starve_q >= STARVE_C);

  // Starve counter: counts consecutive stalled beats, clears on slot or idle CPU.
  always_comb begin
    starve_d = starve_q;
    if (state_q != S_BURST) begin
      starve_d = 8'd0;
    end else if (slot_s) begin
      starve_d = 8'd0;
    end else if (cpu_req_s) begin
      starve_d = starve_q + 8'd1;
    end else begin
      starve_d = 8'd0;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 8'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign slot_s = 1'b0;
`endif

  // Effective burst length: zero means one beat, anything above MAX_LEN is clamped.
  always_comb begin
    eff_len_s = dbg_len;
    if (dbg_len == 8'd0) begin
      eff_len_s = 8'd1;
    end else if (dbg_len > MAX_LEN_C) begin
      eff_len_s = MAX_LEN_C;
    end else begin
      eff_len_s = dbg_len;
    end
  end

  // A debug beat executes only in BURST, outside forced CPU slots and reset.
  assign own_dbg_s = (state_q == S_BURST) && !slot_s && !rst;

  // Next-state logic for the arbitration FSM and the burst address/count.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (dbg_req) begin
          we_d    = dbg_we;
          addr_d  = {dbg_addr[31:2], 2'b00};
          cnt_d   = eff_len_s;
          state_d = S_BURST;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BURST: begin
        if (slot_s) begin
          state_d = S_BURST;
        end else begin
          addr_d = addr_q + 32'd4;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d = S_DONE;
          end else begin
            state_d = S_BURST;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    gnt_d  = (state_d == S_BURST);
    done_d = (state_d == S_DONE);
  end

  // FSM state, burst context and registered grant/done outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      cnt_q   <= 8'd0;
      gnt_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

  // Port mux: debug beat drives a word access, otherwise the CPU passes through.
  always_comb begin
    mem_access = cpu_access;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_load   = 1'b0;
    mem_store  = 1'b0;
    if (rst) begin
      mem_load  = 1'b0;
      mem_store = 1'b0;
    end else if (own_dbg_s) begin
      mem_load   = ~we_q;
      mem_store  = we_q;
      mem_access = 3'b010;
      mem_addr   = addr_q;
      mem_wdata  = dbg_wdata;
    end else begin
      mem_load   = cpu_load;
      mem_store  = cpu_store;
      mem_access = cpu_access;
      mem_addr   = cpu_addr;
      mem_wdata  = cpu_wdata;
    end
  end

  assign cpu_stall = own_dbg_s & cpu_req_s;
  assign dbg_valid = own_dbg_s;
  assign dbg_gnt   = gnt_q;
  assign dbg_done  = done_q;
  assign cpu_rdata = mem_rdata;
  assign dbg_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory standing in
// for mmio (256 words, indexed by address bits [9:2]).
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_load, cpu_store;
  logic [2:0]  cpu_access;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req, dbg_we;
  logic [31:0] dbg_addr;
  logic [7:0]  dbg_len;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt, dbg_valid, dbg_done;
  logic [31:0] dbg_rdata;
  logic        mem_load, mem_store;
  logic [2:0]  mem_access;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  logic [31:0] mem [0:255] = '{default: 32'h0};

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_rdata[$];
  int          r_beats, r_stalls, r_done_cyc, r_first, r_last, r_gnt;
  logic        r_done_stall, r_done_mload;
  logic [31:0] r_done_rdata;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .cpu_load(cpu_load), .cpu_store(cpu_store), .cpu_access(cpu_access),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_len(dbg_len),
    .dbg_wdata(dbg_wdata), .dbg_gnt(dbg_gnt), .dbg_valid(dbg_valid),
    .dbg_rdata(dbg_rdata), .dbg_done(dbg_done),
    .mem_load(mem_load), .mem_store(mem_store), .mem_access(mem_access),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[9:2]];

  // Memory model write port.
  always @(posedge clk) begin
    if (mem_store) mem[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run one burst from IDLE; dbg_req is held only in the request cycle.
  task automatic run_burst(input logic we, input logic [31:0] addr, input logic [7:0] len,
                           input logic [31:0] wbase, input logic cpu_ld);
    q_addr.delete();
    q_rdata.delete();
    r_beats = 0; r_stalls = 0; r_done_cyc = -1; r_first = -1; r_last = -1; r_gnt = 0;
    r_done_stall = 1'b1; r_done_mload = 1'b0; r_done_rdata = 32'h0;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_len = len;
    cpu_load = cpu_ld; cpu_addr = 32'h100; cpu_access = 3'b010;
    for (int c = 0; c < 40 && r_done_cyc < 0; c++) begin
      dbg_wdata = wbase + 32'(r_beats);
      @(negedge clk);
      if (dbg_valid) begin
        if (r_beats == 0) r_first = c;
        r_last = c;
        r_beats++;
        q_addr.push_back(mem_addr);
        q_rdata.push_back(dbg_rdata);
        if (dbg_gnt) r_gnt++;
      end
      if (cpu_stall) r_stalls++;
      if (dbg_done) begin
        r_done_cyc   = c;
        r_done_stall = cpu_stall;
        r_done_mload = mem_load;
        r_done_rdata = cpu_rdata;
      end
      step();
      dbg_req = 1'b0;
    end
    cpu_load = 1'b0;
  endtask

  initial begin
    logic [9:0] v_vec, s_vec, d_vec, c_vec;
    int dcount;

    rst = 1'b1;
    cpu_load = 1'b1; cpu_store = 1'b0; cpu_access = 3'b010;
    cpu_addr = 32'h100; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_len = 8'd0; dbg_wdata = 32'h0;

    // Reset behaviour
    step();
    @(negedge clk);
    check("rst_mem_load", {31'd0, mem_load}, 32'd0);
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    step();
    rst = 1'b0;
    cpu_load = 1'b0;
    @(negedge clk);
    check("rst_gnt", {31'd0, dbg_gnt}, 32'd0);
    check("rst_valid", {31'd0, dbg_valid}, 32'd0);
    check("rst_done", {31'd0, dbg_done}, 32'd0);
    step();

    // Idle pass-through
    cpu_store = 1'b1; cpu_addr = 32'h100; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    check("idle_store", {31'd0, mem_store}, 32'd1);
    check("idle_store_stall", {31'd0, cpu_stall}, 32'd0);
    step();
    cpu_store = 1'b0; cpu_load = 1'b1;
    @(negedge clk);
    check("idle_load_data", cpu_rdata, 32'hDEADBEEF);
    check("idle_load_stall", {31'd0, cpu_stall}, 32'd0);
    step();
    cpu_load = 1'b0;

    // Write burst, misaligned start 0x203 -> 0x200, data 1..4
    run_burst(1'b1, 32'h203, 8'd4, 32'd1, 1'b0);
    check("wr_beats", 32'(r_beats), 32'd4);
    check("wr_done_cyc", 32'(r_done_cyc), 32'd5);
    check("wr_gnt", 32'(r_gnt), 32'd4);
    check("wr_addr0", q_addr[0], 32'h200);
    check("wr_addr3", q_addr[3], 32'h20C);
    for (int i = 0; i < 4; i++) check("wr_mem", mem[128 + i], 32'(i + 1));

    // Read burst readback
    run_burst(1'b0, 32'h200, 8'd4, 32'd0, 1'b0);
    check("rd_beats", 32'(r_beats), 32'd4);
    for (int i = 0; i < 4; i++) check("rd_data", q_rdata[i], 32'(i + 1));

    // Length edges
    run_burst(1'b0, 32'h0, 8'd0, 32'd0, 1'b0);
    check("len0_beats", 32'(r_beats), 32'd1);
    check("len0_done_cyc", 32'(r_done_cyc), 32'd2);
    run_burst(1'b0, 32'h0, 8'd200, 32'd0, 1'b0);
    check("len200_beats", 32'(r_beats), 32'd16);
    check("len200_done_cyc", 32'(r_done_cyc), 32'd17);

    // Address wrap 0xFFFFFFF8 -> 0xFFFFFFFC -> 0x0
    run_burst(1'b1, 32'hFFFF_FFF8, 8'd3, 32'h51, 1'b0);
    check("wrap_addr1", q_addr[1], 32'hFFFF_FFFC);
    check("wrap_addr2", q_addr[2], 32'h0);
    check("wrap_mem255", mem[255], 32'h52);
    check("wrap_mem0", mem[0], 32'h53);

    // CPU contention: load held through a 16-beat burst
    run_burst(1'b0, 32'h0, 8'd16, 32'd0, 1'b1);
    check("cont_beats", 32'(r_beats), 32'd16);
    check("cont_stalls", 32'(r_stalls), 32'd16);
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("cont_span", 32'(r_last - r_first + 1), 32'd17);
`else
    check("cont_span", 32'(r_last - r_first + 1), 32'd16);
`endif
    check("cont_done_stall", {31'd0, r_done_stall}, 32'd0);
    check("cont_done_mload", {31'd0, r_done_mload}, 32'd1);
    check("cont_done_rdata", r_done_rdata, 32'hDEADBEEF);

    // Back-to-back bursts with dbg_req held and a pending CPU load
    v_vec = 10'd0; s_vec = 10'd0; d_vec = 10'd0; c_vec = 10'd0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_len = 8'd2;
    cpu_load = 1'b1; cpu_addr = 32'h100;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      v_vec[c] = dbg_valid;
      s_vec[c] = cpu_stall;
      d_vec[c] = dbg_done;
      c_vec[c] = mem_load && (mem_addr == 32'h100) && !cpu_stall && (cpu_rdata == 32'hDEADBEEF);
      step();
      if (c == 4) dbg_req = 1'b0;
    end
    cpu_load = 1'b0;
    check("b2b_valid", {22'd0, v_vec}, {22'd0, 10'b0001100110});
    check("b2b_stall", {22'd0, s_vec}, {22'd0, 10'b0001100110});
    check("b2b_done", {22'd0, d_vec}, {22'd0, 10'b0010001000});
    check("b2b_cpu_slot", {22'd0, c_vec}, {22'd0, 10'b1110011001});

    // Reset in the cycle after beat 2 of a len-8 write burst
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h300; dbg_len = 8'd8;
    cpu_load = 1'b1; cpu_addr = 32'h100;
    for (int c = 0; c < 3; c++) begin
      dbg_wdata = 32'hA0 + 32'(c) - 32'd1;
      @(negedge clk);
      step();
      dbg_req = 1'b0;
    end
    rst = 1'b1;
    dbg_wdata = 32'hA2;
    @(negedge clk);
    check("rstb_mem_store", {31'd0, mem_store}, 32'd0);
    check("rstb_mem_load", {31'd0, mem_load}, 32'd0);
    check("rstb_stall", {31'd0, cpu_stall}, 32'd0);
    step();
    rst = 1'b0;
    cpu_load = 1'b0;
    @(negedge clk);
    check("rsta_gnt", {31'd0, dbg_gnt}, 32'd0);
    check("rsta_valid", {31'd0, dbg_valid}, 32'd0);
    check("rsta_mem_store", {31'd0, mem_store}, 32'd0);
    dcount = 0;
    for (int c = 0; c < 4; c++) begin
      if (dbg_done) dcount++;
      step();
      @(negedge clk);
    end
    check("rsta_no_done", 32'(dcount), 32'd0);
    check("rsta_mem0", mem[192], 32'hA0);
    check("rsta_mem1", mem[193], 32'hA1);
    check("rsta_mem2", mem[194], 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single data-memory/MMIO port between the single-cycle CPU's load/store path and a debug/loader requester that issues word bursts. The block sits between the CPU datapath and the `mmio` block, replacing the CPU's direct connection. It generates `cpu_stall`, which top-level integration ORs into the CPU `halt` input and uses to gate register-file `write_ena`. A stalled instruction therefore neither advances the PC nor retires.

## Interface
Parameters:
- `MAX_LEN`, default 16: maximum beats per debug burst; a larger `dbg_len` is clamped to this value.
- `STARVE_LIMIT`, default 8: consecutive CPU-stall beats before a forced CPU slot; used only with the macro defined.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `cpu_load`, `cpu_store` in 1: CPU memory request, combinational from the decoder.
- `cpu_access` in 3: funct3 access type.
- `cpu_addr` in 32: CPU byte address.
- `cpu_wdata` in 32: CPU store data.
- `cpu_rdata` out 32: equals `mem_rdata`.
- `cpu_stall` out 1: the CPU has a pending access but does not own the port.
- `dbg_req` in 1: burst request, sampled only in IDLE.
- `dbg_we` in 1: 1 selects a write burst, 0 a read burst.
- `dbg_addr` in 32: start address; bits [1:0] are ignored (forced to 0).
- `dbg_len` in 8: beat count; 0 is treated as 1.
- `dbg_wdata` in 32: write data, consumed in each `dbg_valid` cycle.
- `dbg_gnt` out 1: registered, high for the whole BURST state.
- `dbg_valid` out 1: a beat executes this cycle; read data is on `dbg_rdata`.
- `dbg_rdata` out 32: equals `mem_rdata`.
- `dbg_done` out 1: one-cycle pulse in the DONE state.
- `mem_load`, `mem_store` out 1: drive `mmio`.
- `mem_access` out 3: drives `mmio`.
- `mem_addr` out 32: drives `mmio`.
- `mem_wdata` out 32: drives `mmio`.
- `mem_rdata` in 32: combinational read data from `mmio`.

## Operation
- States: IDLE, BURST, DONE.
  - IDLE: the CPU owns the port. If `dbg_req` is high, capture `dbg_we`, `{dbg_addr[31:2],2'b00}` and the effective length L (= max(1, min(`dbg_len`, MAX_LEN))), then go to BURST.
  - BURST: on each beat cycle, the debug requester owns the port. `mem_load` = ~we, `mem_store` = we, `mem_access` = 3'b010 (word), `mem_addr` = the address register. After each beat the address increments by 4 (wraps modulo 2^32) and the remaining count decrements. After the beat that takes the remaining count from 1 to 0, go to DONE.
  - DONE: the CPU owns the port and `dbg_done` = 1; go to IDLE next cycle. This guarantees the CPU one slot after every burst.
- When the CPU owns the port, `mem_*` pass the `cpu_*` inputs through unchanged and `cpu_stall` = 0.
- When the debug requester owns the port, `cpu_stall` = `cpu_load | cpu_store` (combinational).
- `dbg_req` is ignored outside IDLE. Dropping it mid-burst does not abort the burst; only `rst` aborts.
- If `dbg_req` is still high in DONE, it is re-arbitrated in the following IDLE cycle. The CPU therefore gets at least one IDLE and one DONE cycle between bursts.
- Reset values: state IDLE; `dbg_gnt`, `dbg_valid`, `dbg_done` = 0; counters and address register = 0. While `rst` is high, `mem_load` = `mem_store` = 0 and `cpu_stall` = 0.
- Reset mid-burst: the burst is abandoned with no `dbg_done`, and no write occurs in the reset cycle.

## Timing
- Grant latency: `dbg_req` high in IDLE cycle N gives BURST from cycle N+1; the first beat is in N+1, with `dbg_gnt` = 1 from N+1.
- Burst of L beats with no forced slots: beats in cycles N+1..N+L, DONE in N+L+1, IDLE in N+L+2.
- Read data is combinational: `dbg_rdata` is valid in the same cycle as `dbg_valid`.
- `dbg_wdata` must be stable during each `dbg_valid` cycle. The requester advances its write data on the cycle after each `dbg_valid`.
- `cpu_stall` has no register stage; the CPU holds its PC and request until `cpu_stall` falls.

## Configuration
- `MEM_ARB_STARVE_GUARD_EN` defined:
  - In BURST, a starve counter increments on each beat cycle in which `cpu_load|cpu_store` is high.
  - When the counter reaches STARVE_LIMIT, the next BURST cycle is a CPU slot: `dbg_valid` = 0, CPU pass-through, `cpu_stall` = 0, no address or count change, and the counter clears.
  - The counter also clears on any beat cycle where the CPU has no request, and in IDLE.
- `MEM_ARB_STARVE_GUARD_EN` undefined: no counter and no forced slots. A burst always runs L consecutive beats.

## Test plan
- Idle pass-through: no `dbg_req`, CPU store 0xDEADBEEF to 0x100, then load from 0x100. Required: `cpu_rdata` = 0xDEADBEEF and `cpu_stall` never asserts.
- Write burst: `dbg_req` with we=1, addr 0x203 (aligned to 0x200), len 4, data 1..4. Required: 4 `dbg_valid` cycles, words 1..4 at 0x200..0x20C, `dbg_done` 5 cycles after the request, then readback of those words by a read burst.
- Length edges: `dbg_len` = 0 gives exactly 1 beat; `dbg_len` = 200 gives exactly MAX_LEN (16) beats. Address wraps from 0xFFFFFFFC to 0x0.
- CPU contention: CPU issues a load every cycle during a 16-beat burst. Without the macro, `cpu_stall` is high for 16 cycles and the load completes in DONE. With the macro and STARVE_LIMIT 8, exactly one CPU slot after beat 8, and the burst spans 17 cycles.
- Back-to-back requests: `dbg_req` held high through two bursts. Required: DONE then IDLE separate the bursts, and a pending CPU access completes in both cycles.
- Reset mid-burst: `rst` asserted at beat 2 of a len-8 write burst. Required: next cycle is IDLE, no `dbg_done`, only 2 words written, and all outputs at their reset values.
